// File: rtl/list_accum_engine_pkg.sv
// ============================================================================
// list_accum_engine_pkg
//   Shared types for the linked-list reduction engine: modes, FSM states and
//   the list terminator.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package list_accum_engine_pkg;

  typedef enum logic [1:0] {
    MODE_SUM   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_MAX   = 2'd2,
    MODE_MIN   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACC   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A next field equal to this address terminates the list.
  localparam int unsigned NIL_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/list_accum_engine_if.sv
// ============================================================================
// list_accum_engine_if
//   Control, node-load and result bundle between the board top and the engine.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface list_accum_engine_if
  import list_accum_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic                     step_en;
  logic                     start;
  mode_e                    mode;
  logic [ADDR_W-1:0]        head;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_value;
  logic [ADDR_W-1:0]        wr_next;
  logic                     busy;
  logic                     done;
  logic                     err_loop;
  logic [DATA_W+ADDR_W-1:0] result;

  modport master (
    output step_en, start, mode, head, wr_en, wr_addr, wr_value, wr_next,
    input  busy, done, err_loop, result
  );

  modport slave (
    input  step_en, start, mode, head, wr_en, wr_addr, wr_value, wr_next,
    output busy, done, err_loop, result
  );

endinterface

`default_nettype wire

// File: rtl/list_accum_engine_node_ram.sv
// ============================================================================
// list_node_ram
//   DEPTH x (value,next) node store: one synchronous write port and one
//   synchronous read port. Contents are deliberately not reset.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module list_node_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  wire logic                     clk,
  input  wire logic                     wr_en_i,
  input  wire logic [ADDR_W-1:0]        wr_addr_i,
  input  wire logic [DATA_W+ADDR_W-1:0] wr_data_i,
  input  wire logic                     rd_en_i,
  input  wire logic [ADDR_W-1:0]        rd_addr_i,
  output logic      [DATA_W+ADDR_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WORD_W = DATA_W + ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  // Read data is held between reads so a stalled walk keeps its node.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/list_accum_engine.sv
// ============================================================================
// list_accum_engine
//   Walks a linked list in the node RAM from a programmable head and reduces
//   node values (SUM/COUNT/MAX/MIN), with a visited-node guard against loops.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module list_accum_engine
  import list_accum_engine_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int MAX_NODES = 2 ** ADDR_W
) (
  input wire logic                   clk,
  input wire logic                   rst,
  list_accum_engine_if.slave         bus
);

  localparam int RES_W = DATA_W + ADDR_W;
  localparam int CNT_W = $clog2(MAX_NODES + 1);

  state_e             state_q;
  mode_e              mode_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RES_W-1:0]   acc_q;
  logic [RES_W-1:0]   result_q;
  logic               busy_q;
  logic               done_q;
  logic               err_loop_q;

  logic [CNT_W-1:0]   cnt_d;
  logic [RES_W-1:0]   acc_d;
  logic [RES_W-1:0]   acc_init;
  logic [RES_W-1:0]   node_val_ext;
  logic [ADDR_W-1:0]  node_next;
  logic [RES_W-1:0]   rd_data;
  logic               ram_wr_en;
  logic               ram_rd_en;

  // Writes are dropped, not queued, while a walk is in flight.
  assign ram_wr_en = bus.wr_en && !busy_q;
  assign ram_rd_en = (state_q == ST_FETCH) && bus.step_en;

  list_node_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_node_ram (
    .clk       (clk),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i ({bus.wr_value, bus.wr_next}),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ptr_q),
    .rd_data_o (rd_data)
  );

  assign node_val_ext = RES_W'(rd_data[RES_W-1 -: DATA_W]);
  assign node_next    = rd_data[ADDR_W-1:0];
  assign acc_init     = (bus.mode == MODE_MIN) ? {RES_W{1'b1}} : '0;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    acc_d = acc_q;
    case (mode_q)
      MODE_SUM:   acc_d = acc_q + node_val_ext;
      MODE_COUNT: acc_d = acc_q + RES_W'(1);
      MODE_MAX:   acc_d = (node_val_ext > acc_q) ? node_val_ext : acc_q;
      MODE_MIN:   acc_d = (node_val_ext < acc_q) ? node_val_ext : acc_q;
      default:    acc_d = acc_q;
    endcase
  end

  // Result and done are registered on the ACC->DONE edge so both are valid
  // during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SUM;
      ptr_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_loop_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.step_en && bus.start) begin
            mode_q     <= bus.mode;
            ptr_q      <= bus.head;
            cnt_q      <= '0;
            acc_q      <= acc_init;
            err_loop_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.step_en) begin
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (bus.step_en) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (node_next == ADDR_W'(NIL_ADDR)) begin
              result_q <= acc_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else if (cnt_d == CNT_W'(MAX_NODES)) begin
              result_q   <= acc_d;
              done_q     <= 1'b1;
              err_loop_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              ptr_q   <= node_next;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_loop = err_loop_q;
  assign bus.result   = result_q;

endmodule

`default_nettype wire
